e_mdu: RTL and testbench

- Execute-stage multiply/divide unit for the P6 pipelined MIPS core. It sits beside the E-stage ALU and shares the same operand buses.
- Runs the multi-cycle MULT/MULTU/DIV/DIVU into private HI/LO registers and services MFHI/MFLO/MTHI/MTLO.
- Exposes a busy flag that the hazard unit uses to stall D-stage MDU instructions.

---
 rtl/e_mdu_if.sv | 19 +
 rtl/e_mdu.sv | 123 ++++++++++++
 tb/tb_e_mdu.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/e_mdu_if.sv
// Operand/control bundle between the E stage and the multiply/divide unit.
interface e_mdu_if;
  logic [31:0] E_data1;
  logic [31:0] E_data2;
  logic [3:0]  E_mdu_op;
  logic        E_start;
  logic        E_busy;
  logic [31:0] E_mdu_out;

  modport master (
    output E_data1, E_data2, E_mdu_op, E_start,
    input  E_busy, E_mdu_out
  );

  modport slave (
    input  E_data1, E_data2, E_mdu_op, E_start,
    output E_busy, E_mdu_out
  );
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: result computed at start, committed to HI/LO
// after a fixed busy period; MFHI/MFLO read the architectural HI/LO.
module e_mdu #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic   clk,
  input  logic   reset,
  e_mdu_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DW    = 32;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [DW-1:0]    hi, hi_d, lo, lo_d;
  logic [DW-1:0]    res_hi, res_hi_d, res_lo, res_lo_d;
  logic             div0, div0_d;

  // Datapath: one-shot product and quotient/remainder of the current operands
  logic            is_signed, a_neg, b_neg;
  logic [DW-1:0]   a_mag, b_mag, q_mag, r_mag, quo, rem;
  logic [2*DW-1:0] prod;

  always_comb begin
    is_signed = (bus.E_mdu_op == OP_MULT) || (bus.E_mdu_op == OP_DIV);
    a_neg     = is_signed & bus.E_data1[DW-1];
    b_neg     = is_signed & bus.E_data2[DW-1];
    a_mag     = a_neg ? DW'(32'd0 - bus.E_data1) : bus.E_data1;
    b_mag     = b_neg ? DW'(32'd0 - bus.E_data2) : bus.E_data2;
    q_mag     = (b_mag != '0) ? a_mag / b_mag : '0;
    r_mag     = (b_mag != '0) ? a_mag % b_mag : '0;
    // Magnitude divide avoids the INT_MIN / -1 overflow corner entirely
    quo       = (a_neg ^ b_neg) ? DW'(32'd0 - q_mag) : q_mag;
    rem       = a_neg ? DW'(32'd0 - r_mag) : r_mag;
    if (is_signed)
      prod = (2*DW)'({{DW{bus.E_data1[DW-1]}}, bus.E_data1} *
                     {{DW{bus.E_data2[DW-1]}}, bus.E_data2});
    else
      prod = (2*DW)'({{DW{1'b0}}, bus.E_data1} * {{DW{1'b0}}, bus.E_data2});
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      res_hi <= '0;
      res_lo <= '0;
      div0   <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      hi     <= hi_d;
      lo     <= lo_d;
      res_hi <= res_hi_d;
      res_lo <= res_lo_d;
      div0   <= div0_d;
    end
  end

  // Next-state: start / move-to in IDLE, count down and commit in RUN
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    hi_d     = hi;
    lo_d     = lo;
    res_hi_d = res_hi;
    res_lo_d = res_lo;
    div0_d   = div0;
    unique case (state)
      IDLE: begin
        if (bus.E_start && (bus.E_mdu_op == OP_MULT || bus.E_mdu_op == OP_MULTU)) begin
          res_hi_d = prod[2*DW-1:DW];
          res_lo_d = prod[DW-1:0];
          div0_d   = 1'b0;
          cnt_d    = CNT_W'(MULT_LAT);
          state_d  = RUN;
        end else if (bus.E_start && (bus.E_mdu_op == OP_DIV || bus.E_mdu_op == OP_DIVU)) begin
          res_hi_d = rem;
          res_lo_d = quo;
          div0_d   = (bus.E_data2 == '0);
          cnt_d    = CNT_W'(DIV_LAT);
          state_d  = RUN;
        end else if (bus.E_mdu_op == OP_MTHI) begin
          hi_d = bus.E_data1;
        end else if (bus.E_mdu_op == OP_MTLO) begin
          lo_d = bus.E_data1;
        end
      end
      RUN: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_d = IDLE;
          if (!div0) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.E_busy    = (cnt != '0);
  assign bus.E_mdu_out = (bus.E_mdu_op == OP_MFHI) ? hi :
                         (bus.E_mdu_op == OP_MFLO) ? lo : '0;

endmodule

// File: tb/tb_e_mdu.sv
// Randomized and directed bench for e_mdu against a 64-bit arithmetic model.
module tb_e_mdu;

  localparam int unsigned MULT_LAT = 5;
  localparam int unsigned DIV_LAT  = 10;

  logic clk = 1'b0;
  logic reset;
  e_mdu_if bus();

  e_mdu #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi, m_lo;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: what {HI,LO} become for an op, and whether they are written
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic wr, output logic [31:0] rh, output logic [31:0] rl);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    wr = 1'b1; rh = m_hi; rl = m_lo;
    case (op)
      4'd1: begin sq = sa * sb; rh = sq[63:32]; rl = sq[31:0]; end
      4'd2: begin up = ua * ub; rh = up[63:32]; rl = up[31:0]; end
      4'd3: if (b == 0) wr = 1'b0;
            else begin sq = sa / sb; sr = sa % sb; rl = sq[31:0]; rh = sr[31:0]; end
      4'd4: if (b == 0) wr = 1'b0;
            else begin up = ua / ub; rl = up[31:0]; up = ua % ub; rh = up[31:0]; end
      default: wr = 1'b0;
    endcase
  endtask

  task automatic idle_inputs();
    bus.E_start = 1'b0; bus.E_mdu_op = 4'd0; bus.E_data1 = '0; bus.E_data2 = '0;
  endtask

  task automatic read_hilo(input string tag);
    bus.E_mdu_op = 4'd5; #1; check({tag, "_hi"}, bus.E_mdu_out, m_hi);
    bus.E_mdu_op = 4'd6; #1; check({tag, "_lo"}, bus.E_mdu_out, m_lo);
    bus.E_mdu_op = 4'd0; #1; check({tag, "_none"}, bus.E_mdu_out, 32'd0);
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] v);
    bus.E_mdu_op = op; bus.E_data1 = v;
    @(negedge clk);
    if (op == 4'd7) m_hi = v; else m_lo = v;
    idle_inputs();
  endtask

  // Issue a start at the next posedge; optionally poke the unit while busy
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit inject);
    logic wr; logic [31:0] rh, rl;
    int lat;
    model(op, a, b, wr, rh, rl);
    lat = (op == 4'd1 || op == 4'd2) ? int'(MULT_LAT) : int'(DIV_LAT);
    bus.E_start = 1'b1; bus.E_mdu_op = op; bus.E_data1 = a; bus.E_data2 = b;
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < lat; i++) begin
      check({tag, "_busy"}, {31'd0, bus.E_busy}, 32'd1);
      if (inject && i == 1) begin
        bus.E_start = 1'b1; bus.E_mdu_op = 4'd3; bus.E_data1 = 32'd100; bus.E_data2 = 32'd7;
      end else if (inject && i == 2) begin
        bus.E_start = 1'b0; bus.E_mdu_op = 4'd8; bus.E_data1 = 32'h0000AAAA;
      end else begin
        idle_inputs();
      end
      if (i + 1 < lat) begin
        bus.E_mdu_op = (bus.E_mdu_op == 4'd0) ? 4'd5 : bus.E_mdu_op;
        #1;
        if (bus.E_mdu_op == 4'd5) check({tag, "_old_hi"}, bus.E_mdu_out, m_hi);
      end
      @(negedge clk);
    end
    idle_inputs();
    check({tag, "_done"}, {31'd0, bus.E_busy}, 32'd0);
    if (wr) begin m_hi = rh; m_lo = rl; end
    read_hilo(tag);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    idle_inputs();
    m_hi = '0; m_lo = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {31'd0, bus.E_busy}, 32'd0);
    read_hilo("rst");

    run_op("mult",  4'd1, 32'hFFFFFFFE, 32'h3, 1'b0);
    check("mult_hi_abs", m_hi, 32'hFFFFFFFF);
    check("mult_lo_abs", m_lo, 32'hFFFFFFFA);
    run_op("multu", 4'd2, 32'hFFFFFFFE, 32'h3, 1'b0);
    check("multu_hi_abs", m_hi, 32'h00000002);
    run_op("div",   4'd3, 32'hFFFFFFF9, 32'h2, 1'b0);
    check("div_lo_abs", m_lo, 32'hFFFFFFFD);
    check("div_hi_abs", m_hi, 32'hFFFFFFFF);
    run_op("divu",  4'd4, 32'd7, 32'd2, 1'b0);
    check("divu_lo_abs", m_lo, 32'd3);

    move_to(4'd7, 32'h12345678);
    read_hilo("mthi");
    run_op("div0",  4'd3, 32'd55, 32'd0, 1'b0);
    check("div0_hi_abs", m_hi, 32'h12345678);
    run_op("ovf",   4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("ovf_lo_abs", m_lo, 32'h80000000);
    check("ovf_hi_abs", m_hi, 32'h0);

    run_op("inject", 4'd1, 32'h00001234, 32'hFFFF0001, 1'b1);

    // Reset during busy cycle 4 of a DIV: no write-back afterwards
    bus.E_start = 1'b1; bus.E_mdu_op = 4'd3; bus.E_data1 = 32'd1000; bus.E_data2 = 32'd3;
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    check("abort_busy_pre", {31'd0, bus.E_busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check("abort_busy", {31'd0, bus.E_busy}, 32'd0);
    read_hilo("abort");
    repeat (11) @(negedge clk);
    check("abort_late_busy", {31'd0, bus.E_busy}, 32'd0);
    read_hilo("abort_late");

    for (int k = 0; k < 40; k++) begin
      op = 4'($urandom_range(1, 12));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(0, 20)) - 32'd10;
      if (op <= 4'd4) run_op("rnd", op, a, b, 1'b0);
      else if (op == 4'd7 || op == 4'd8) move_to(op, a);
      else begin
        bus.E_start = 1'b1; bus.E_mdu_op = op; bus.E_data1 = a; bus.E_data2 = b;
        @(negedge clk);
        idle_inputs();
        check("rnd_ign_busy", {31'd0, bus.E_busy}, 32'd0);
        read_hilo("rnd_ign");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
